led_breath_pwm: RTL and testbench
=================================

Name: led_breath_pwm

Overview:
Downstream stage of the 0.5 s LED blinker. It consumes the blinker's square-wave level and drives the physical LED pin with PWM. Each blinker edge starts a linear brightness ramp, so the LED "breathes" instead of hard-toggling. Single clock domain, the 27 MHz board clock.

Parameters:
PWM_BITS, 8, width of PWM counter and duty register; MAX_DUTY = 2**PWM_BITS-1
PRESCALE, 4, clocks per PWM counter increment (27 MHz/4/256 ≈ 26.4 kHz PWM)
STEP_CYCLES, 52_734, clocks between duty steps (full 0→255 ramp ≈ 0.5 s)
ACTIVE_LOW, 1, 1 = LED lit when led_pwm is 0 (board LEDs are active-low)

Ports:
clock  input  1  system clock, all logic on posedge
reset  input  1  synchronous, active-high reset
toggle_in  input  1  blinker level, same clock domain, registered at source
enable  input  1  1 = run; 0 = force LED dark and return to IDLE_LOW
led_pwm  output  1  PWM drive to LED pin, polarity per ACTIVE_LOW
duty  output  PWM_BITS  current brightness, 0..MAX_DUTY
busy  output  1  1 while in RAMP_UP or RAMP_DOWN

Behaviour:
- Interface: one clock (clock). Reset (reset) is synchronous and active-high.
- Reset values: state=IDLE_LOW, duty=0, pwm_cnt=0, prescale_cnt=0, step_cnt=0, toggle_q=0, busy=0, led_pwm = dark (1 if ACTIVE_LOW, else 0).
- Edge detect: toggle_q <= toggle_in every cycle. rise = toggle_in & ~toggle_q. fall = ~toggle_in & toggle_q. Both are evaluated in the same cycle as the change, and the state updates on the next posedge (1-cycle latency).
- FSM states: IDLE_LOW, RAMP_UP, IDLE_HIGH, RAMP_DOWN.
  - IDLE_LOW --rise--> RAMP_UP.
  - IDLE_HIGH --fall--> RAMP_DOWN.
  - RAMP_UP: duty +1 each time step_cnt reaches STEP_CYCLES-1. At duty==MAX_DUTY, go to IDLE_HIGH.
  - RAMP_DOWN: duty -1 on each step. At duty==0, go to IDLE_LOW.
  - fall in RAMP_UP: go to RAMP_DOWN from the current duty, with no jump.
  - rise in RAMP_DOWN: go to RAMP_UP from the current duty.
  - rise in IDLE_HIGH and fall in IDLE_LOW: ignored.
- step_cnt: clears on every state change. It counts 0..STEP_CYCLES-1 only while in a RAMP state. The first step occurs STEP_CYCLES cycles after the state is entered.
- Duty saturation: duty never wraps. The step that reaches MAX_DUTY or 0 is the final step, and the state leaves RAMP in the same cycle.
- PWM:
  - prescale_cnt counts 0..PRESCALE-1 free-running.
  - pwm_cnt increments when prescale_cnt==PRESCALE-1 and wraps MAX_DUTY→0.
  - lit = (duty==MAX_DUTY) | (pwm_cnt < duty). duty==MAX_DUTY gives 100% on, duty==0 gives 0%.
  - led_pwm is registered: led_pwm <= lit ^ ACTIVE_LOW. This adds 1 cycle of latency versus duty.
- enable=0: next cycle state=IDLE_LOW, duty=0, step_cnt=0, led dark. toggle_q keeps tracking the input. When enable returns to 1 while toggle_in is already high, no ramp starts until the next rise.
- Reset mid-ramp: all state returns to reset values on the next posedge, with no partial ramp continuing.
- busy = state is RAMP_UP or RAMP_DOWN; it is a registered decode.
- Width rules: step_cnt is $clog2(STEP_CYCLES) bits and prescale_cnt is $clog2(PRESCALE) bits, each with a minimum of 1.

Decomposition:
- Package led_pkg: state typedef (IDLE_LOW, RAMP_UP, IDLE_HIGH, RAMP_DOWN), CLK_HZ=27_000_000, default PWM_BITS.
- Sub-module pwm_gen: prescaler, pwm_cnt, compare and output register. Its inputs are duty, and its output is led_pwm.
- The top level keeps the edge detect, FSM, step counter and duty register.

Test Plan:
Bench parameters for all scenarios: PWM_BITS=4, PRESCALE=1, STEP_CYCLES=2, ACTIVE_LOW=1, enable=1 unless noted.
1. Reset then idle 40 cycles with toggle_in=0 -> duty=0, busy=0, led_pwm=1 every cycle.
2. Rise on toggle_in -> busy=1 one cycle later. duty increments every 2 cycles and reaches 15 after 30 cycles in RAMP_UP. State goes to IDLE_HIGH, busy=0, and led_pwm=0 continuously.
3. Ramp up until duty=6, then fall -> RAMP_DOWN starts at duty=6. duty reaches 0 after 12 more cycles, and there is no glitch to 15 or 0.
4. Set duty=8 (hold IDLE_HIGH path, then force a ramp down to 8) and measure over 16 consecutive cycles -> led_pwm=0 for exactly 8 cycles per PWM period.
5. Drop enable mid-ramp at duty=9 -> next cycle duty=0, state IDLE_LOW, led_pwm=1. Re-enable with toggle_in held high -> no ramp until a fresh rise.
6. Assert reset in RAMP_DOWN at duty=5 -> next posedge: duty=0, busy=0, led_pwm=1, all counters 0.

Source files
------------

// File: rtl/led_breath_pwm_pkg.sv
// -----------------------------------------------------------------------------
// led_pkg
// Shared types and defaults for the LED breathing PWM stage.
//   state_t          : ramp FSM states
//   CLK_HZ           : board clock frequency (27 MHz)
//   DEF_PWM_BITS     : default PWM counter / duty width
//   DEF_STEP_CYCLES  : default clocks per duty step, sized so a full
//                      0 -> MAX ramp spans one 0.5 s blinker half-period
//   is_ramp()        : true for the two ramping states
// -----------------------------------------------------------------------------
package led_pkg;

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    RAMP_UP   = 2'd1,
    IDLE_HIGH = 2'd2,
    RAMP_DOWN = 2'd3
  } state_t;

  localparam int CLK_HZ          = 27_000_000;
  localparam int DEF_PWM_BITS    = 8;
  // 27e6 / 2 / 256 = 52_734 clocks per step.
  localparam int DEF_STEP_CYCLES = CLK_HZ / 2 / (2 ** DEF_PWM_BITS);

  function automatic logic is_ramp(input state_t s);
    return (s == RAMP_UP) || (s == RAMP_DOWN);
  endfunction

endpackage

// File: rtl/led_breath_pwm_if.sv
// -----------------------------------------------------------------------------
// led_breath_pwm_if
// Signal bundle between the blinker-side driver and the breathing PWM stage.
//   toggle_in : blinker level (driver -> stage)
//   enable    : run / force dark (driver -> stage)
//   led_pwm   : PWM drive to the LED pin (stage -> driver)
//   duty      : current brightness (stage -> driver)
//   busy      : ramp in progress (stage -> driver)
// Modports: master = driver side, slave = breathing stage.
// -----------------------------------------------------------------------------
interface led_breath_pwm_if
  import led_pkg::*;
#(
  parameter int PWM_BITS = DEF_PWM_BITS
);

  logic                toggle_in;
  logic                enable;
  logic                led_pwm;
  logic [PWM_BITS-1:0] duty;
  logic                busy;

  modport master (
    output toggle_in,
    output enable,
    input  led_pwm,
    input  duty,
    input  busy
  );

  modport slave (
    input  toggle_in,
    input  enable,
    output led_pwm,
    output duty,
    output busy
  );

endinterface

// File: rtl/led_breath_pwm_pwm_gen.sv
// -----------------------------------------------------------------------------
// pwm_gen
// Free-running prescaler and PWM counter, compare against duty, registered
// LED output.
//   clock      : system clock
//   reset      : synchronous, active-high
//   duty       : brightness, 0 = off, MAX = fully on
//   force_dark : 1 = drive the LED dark on the next edge regardless of duty
//   led_pwm    : registered PWM output, inverted when ACTIVE_LOW
// -----------------------------------------------------------------------------
module pwm_gen #(
  parameter int PWM_BITS   = 8,
  parameter int PRESCALE   = 4,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [PWM_BITS-1:0] duty,
  input  logic                force_dark,
  output logic                led_pwm
);

  localparam int                  PS_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0]     PS_LAST  = PS_W'(PRESCALE - 1);
  localparam logic [PWM_BITS-1:0] MAX_DUTY = '1;

  logic [PS_W-1:0]     prescale_cnt;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                tick;
  logic                lit;

  assign tick = (prescale_cnt == PS_LAST);
  // MAX duty is forced fully on; the plain compare would leave one dark slot.
  assign lit  = ~force_dark & ((duty == MAX_DUTY) | (pwm_cnt < duty));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      prescale_cnt <= '0;
      pwm_cnt      <= '0;
      led_pwm      <= ACTIVE_LOW;
    end else begin
      prescale_cnt <= tick ? '0 : prescale_cnt + PS_W'(1);
      // Full-width counter: MAX -> 0 wrap is the natural overflow.
      if (tick) pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      led_pwm      <= lit ^ ACTIVE_LOW;
    end
  end

endmodule

// File: rtl/led_breath_pwm.sv
// -----------------------------------------------------------------------------
// led_breath_pwm
// Turns the blinker's square wave into a breathing LED: each edge of
// toggle_in starts a linear duty ramp toward full-on (rise) or off (fall).
//   clock : system clock (27 MHz board clock)
//   reset : synchronous, active-high
//   bus   : led_breath_pwm_if.slave
//             toggle_in, enable  (in)
//             led_pwm, duty, busy (out)
// -----------------------------------------------------------------------------
module led_breath_pwm
  import led_pkg::*;
#(
  parameter int PWM_BITS    = DEF_PWM_BITS,
  parameter int PRESCALE    = 4,
  parameter int STEP_CYCLES = DEF_STEP_CYCLES,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic            clock,
  input  logic            reset,
  led_breath_pwm_if.slave bus
);

  localparam int                  SC_W      = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [SC_W-1:0]     STEP_LAST = SC_W'(STEP_CYCLES - 1);
  localparam logic [PWM_BITS-1:0] MAX_DUTY  = '1;
  localparam logic [PWM_BITS-1:0] ZERO_DUTY = '0;

  state_t              state_q, state_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic [PWM_BITS-1:0] duty_up, duty_dn;
  logic [SC_W-1:0]     step_cnt, step_d;
  logic                toggle_q;
  logic                busy_q;
  logic                rise, fall, step_hit;

  assign rise     = bus.toggle_in & ~toggle_q;
  assign fall     = ~bus.toggle_in & toggle_q;
  assign step_hit = (step_cnt == STEP_LAST);

  // Saturating neighbours: a ramp entered already at its end point
  // (e.g. fall then immediate rise at MAX) must not wrap.
  assign duty_up = (duty_q == MAX_DUTY)  ? duty_q : duty_q + PWM_BITS'(1);
  assign duty_dn = (duty_q == ZERO_DUTY) ? duty_q : duty_q - PWM_BITS'(1);

  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;

    case (state_q)
      IDLE_LOW:  if (rise) state_d = RAMP_UP;
      IDLE_HIGH: if (fall) state_d = RAMP_DOWN;
      RAMP_UP: begin
        // A direction change wins over a step landing in the same cycle;
        // the ramp reverses from the current duty.
        if (fall) begin
          state_d = RAMP_DOWN;
        end else if (step_hit) begin
          duty_d = duty_up;
          if (duty_up == MAX_DUTY) state_d = IDLE_HIGH;
        end
      end
      RAMP_DOWN: begin
        if (rise) begin
          state_d = RAMP_UP;
        end else if (step_hit) begin
          duty_d = duty_dn;
          if (duty_dn == ZERO_DUTY) state_d = IDLE_LOW;
        end
      end
      default: state_d = IDLE_LOW;
    endcase

    if (!bus.enable) begin
      state_d = IDLE_LOW;
      duty_d  = '0;
    end

    // Step timer restarts on any state change so the first step lands
    // STEP_CYCLES clocks after entering a ramp; it idles at 0 otherwise.
    if ((state_d != state_q) || !is_ramp(state_q) || step_hit) step_d = '0;
    else                                                      step_d = step_cnt + SC_W'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE_LOW;
      duty_q   <= '0;
      step_cnt <= '0;
      toggle_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      duty_q   <= duty_d;
      step_cnt <= step_d;
      toggle_q <= bus.toggle_in;
      busy_q   <= is_ramp(state_d);
    end
  end

  assign bus.duty = duty_q;
  assign bus.busy = busy_q;

  pwm_gen #(
    .PWM_BITS  (PWM_BITS),
    .PRESCALE  (PRESCALE),
    .ACTIVE_LOW(ACTIVE_LOW)
  ) u_pwm_gen (
    .clock     (clock),
    .reset     (reset),
    .duty      (duty_q),
    .force_dark(~bus.enable),
    .led_pwm   (bus.led_pwm)
  );

endmodule

// File: tb/tb_led_breath_pwm.sv
// -----------------------------------------------------------------------------
// tb_led_breath_pwm
// Directed scenarios followed by a randomized phase, all compared each cycle
// against a behavioural model of the breathing LED (ramp direction, elapsed
// time in ramp, PWM phase derived from time since reset).
// -----------------------------------------------------------------------------
module tb_led_breath_pwm;

  localparam int PWM_BITS    = 4;
  localparam int PRESCALE    = 1;
  localparam int STEP_CYCLES = 2;
  localparam bit ACTIVE_LOW  = 1'b1;
  localparam int MAXD        = (1 << PWM_BITS) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  led_breath_pwm_if #(.PWM_BITS(PWM_BITS)) bus ();

  led_breath_pwm #(
    .PWM_BITS   (PWM_BITS),
    .PRESCALE   (PRESCALE),
    .STEP_CYCLES(STEP_CYCLES),
    .ACTIVE_LOW (ACTIVE_LOW)
  ) dut (
    .clock(clk),
    .reset(rst),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: dir = +1 brightening, -1 dimming, 0 resting;
  // top marks resting fully on; age = clocks spent in the current ramp leg.
  bit m_prev;
  int m_dir, m_top, m_duty, m_age, m_time;
  bit m_led, m_busy;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model(input bit tin, input bit en, input bit r);
    bit rise, fall, lit;
    int phase;
    if (r) begin
      m_prev = 0; m_dir = 0; m_top = 0; m_duty = 0; m_age = 0; m_time = 0;
      m_led = ACTIVE_LOW; m_busy = 0;
      return;
    end
    rise   = tin && !m_prev;
    fall   = !tin && m_prev;
    m_prev = tin;
    // LED shows the brightness held before this edge, at the current PWM phase.
    phase  = (m_time / PRESCALE) % (MAXD + 1);
    lit    = en && ((m_duty == MAXD) || (phase < m_duty));
    m_led  = lit ^ ACTIVE_LOW;
    m_time++;
    if (!en) begin
      m_dir = 0; m_top = 0; m_duty = 0; m_age = 0;
    end else if (m_dir == 0 && m_top == 0 && rise) begin
      m_dir = 1; m_age = 0;
    end else if (m_dir == 0 && m_top == 1 && fall) begin
      m_dir = -1; m_top = 0; m_age = 0;
    end else if (m_dir == 1 && fall) begin
      m_dir = -1; m_age = 0;
    end else if (m_dir == -1 && rise) begin
      m_dir = 1; m_age = 0;
    end else if (m_dir != 0) begin
      if (m_age == STEP_CYCLES - 1) begin
        m_age  = 0;
        m_duty = m_duty + m_dir;
        if (m_duty > MAXD) m_duty = MAXD;
        if (m_duty < 0)    m_duty = 0;
        if (m_dir > 0 && m_duty == MAXD) begin m_dir = 0; m_top = 1; end
        else if (m_dir < 0 && m_duty == 0) begin m_dir = 0; m_top = 0; end
      end else begin
        m_age++;
      end
    end
    m_busy = (m_dir != 0);
  endtask

  // One clock: drive inputs, advance model at the edge, compare at negedge.
  task automatic tick(input bit tin, input bit en, input bit r);
    bus.toggle_in = tin;
    bus.enable    = en;
    rst           = r;
    @(posedge clk);
    model(tin, en, r);
    @(negedge clk);
    check("duty",    32'(bus.duty),    32'(m_duty));
    check("busy",    32'(bus.busy),    32'(m_busy));
    check("led_pwm", 32'(bus.led_pwm), 32'(m_led));
  endtask

  task automatic run_to_duty(input int target, input bit tin, input string tag);
    int n = 0;
    while (m_duty != target && n < 64) begin
      tick(tin, 1'b1, 1'b0);
      n++;
    end
    check(tag, 32'(bus.duty), 32'(target));
  endtask

  initial begin
    int lows;
    bit tin, en, r;

    // 1. Reset, then idle dark.
    tick(1'b0, 1'b1, 1'b1);
    tick(1'b0, 1'b1, 1'b1);
    check("reset_duty", 32'(bus.duty), 32'd0);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_led",  32'(bus.led_pwm), 32'd1);
    for (int i = 0; i < 40; i++) tick(1'b0, 1'b1, 1'b0);
    check("idle_led", 32'(bus.led_pwm), 32'd1);

    // 2. Full ramp up: busy one cycle after the rise, MAX after 30 cycles.
    tick(1'b1, 1'b1, 1'b0);
    check("rise_busy", 32'(bus.busy), 32'd1);
    for (int i = 0; i < 30; i++) tick(1'b1, 1'b1, 1'b0);
    check("up_full_duty", 32'(bus.duty), 32'd15);
    check("up_full_busy", 32'(bus.busy), 32'd0);
    for (int i = 0; i < 20; i++) tick(1'b1, 1'b1, 1'b0);
    check("full_on_led", 32'(bus.led_pwm), 32'd0);

    // 4. Dim to 8, then freeze duty by toggling every cycle; count lit slots.
    run_to_duty(8, 1'b0, "down_to_8");
    tin  = 1'b0;
    tin  = ~tin;
    tick(tin, 1'b1, 1'b0);
    lows = 0;
    for (int i = 0; i < 16; i++) begin
      tin = ~tin;
      tick(tin, 1'b1, 1'b0);
      if (bus.led_pwm == 1'b0) lows++;
    end
    check("half_duty_lit_slots", 32'(lows), 32'd8);
    check("half_duty_hold", 32'(bus.duty), 32'd8);

    // 3. Reverse mid-ramp at 6: back to 0 in 12 cycles.
    tick(1'b0, 1'b1, 1'b1);
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    run_to_duty(6, 1'b1, "up_to_6");
    tick(1'b0, 1'b1, 1'b0);
    check("reverse_duty", 32'(bus.duty), 32'd6);
    check("reverse_busy", 32'(bus.busy), 32'd1);
    for (int i = 0; i < 11; i++) tick(1'b0, 1'b1, 1'b0);
    check("down_not_yet_0", 32'(bus.duty), 32'd1);
    tick(1'b0, 1'b1, 1'b0);
    check("down_reach_0", 32'(bus.duty), 32'd0);
    check("down_idle_busy", 32'(bus.busy), 32'd0);

    // 5. Drop enable at 9; re-enable with input already high.
    run_to_duty(9, 1'b1, "up_to_9");
    tick(1'b1, 1'b0, 1'b0);
    check("disable_duty", 32'(bus.duty), 32'd0);
    check("disable_busy", 32'(bus.busy), 32'd0);
    check("disable_led",  32'(bus.led_pwm), 32'd1);
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) tick(1'b1, 1'b1, 1'b0);
    check("reenable_no_ramp", 32'(bus.busy), 32'd0);
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    check("fresh_rise_busy", 32'(bus.busy), 32'd1);

    // 6. Reset while dimming at 5.
    run_to_duty(7, 1'b1, "up_to_7");
    tick(1'b0, 1'b1, 1'b0);
    run_to_duty(5, 1'b0, "down_to_5");
    tick(1'b0, 1'b1, 1'b1);
    check("rst_mid_duty", 32'(bus.duty), 32'd0);
    check("rst_mid_busy", 32'(bus.busy), 32'd0);
    check("rst_mid_led",  32'(bus.led_pwm), 32'd1);

    // Randomized phase: sparse edges, occasional disable and reset.
    tin = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7, 0) == 0) tin = ~tin;
      en = ($urandom_range(63, 0) != 0);
      r  = ($urandom_range(511, 0) == 0);
      tick(tin, en, r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
